// File: rtl/iopage_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iopage_master_pkg
// Description : Shared definitions for the iopage register bus. Holds the
//               bus address/data widths, the initiator state encodings and a
//               helper that forms the device-side address. Device register
//               blocks import this package for the same widths.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package iopage_master_pkg;

  localparam int IOPAGE_AW = 13;
  localparam int IOPAGE_DW = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Devices always return a full word, so every access except a byte write
  // presents the even address. A byte write keeps bit0 so the device can
  // pick the lane to update.
  function automatic logic [IOPAGE_AW-1:0] dev_addr(
    input logic [IOPAGE_AW-1:0] addr,
    input logic                 we,
    input logic                 byte_op
  );
    dev_addr = {addr[IOPAGE_AW-1:1], addr[0] & we & byte_op};
  endfunction

endpackage
`default_nettype wire

// File: rtl/iopage_lane_steer.sv
`default_nettype none
// ============================================================================
// Module      : iopage_lane_steer
// Description : Combinational byte-lane steering for the iopage initiator.
//               Write side replicates the byte onto both lanes; read side
//               selects the addressed byte and zero-extends it.
// Ports       : byte_op   - access is a byte access
//               addr_lsb  - bit0 of the CPU byte address
//               wdata     - CPU write data (byte in [7:0])
//               dev_rdata - full word returned by the devices
//               wr_data   - steered write data toward the devices
//               rd_data   - steered read data toward the CPU
// Revision    : 1.0 - initial release
// ============================================================================
module iopage_lane_steer
  import iopage_master_pkg::*;
(
  input  logic                 byte_op,
  input  logic                 addr_lsb,
  input  logic [IOPAGE_DW-1:0] wdata,
  input  logic [IOPAGE_DW-1:0] dev_rdata,
  output logic [IOPAGE_DW-1:0] wr_data,
  output logic [IOPAGE_DW-1:0] rd_data
);

  // Byte written on both lanes so the device need not look at bit0 to find it.
  assign wr_data = byte_op ? {wdata[7:0], wdata[7:0]} : wdata;

  always_comb begin
    rd_data = dev_rdata;
    if (byte_op) begin
      if (addr_lsb) rd_data = {8'h00, dev_rdata[15:8]};
      else          rd_data = {8'h00, dev_rdata[7:0]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/iopage_master.sv
`default_nettype none
// ============================================================================
// Module      : iopage_master
// Description : Initiator side of the iopage register bus. Takes single
//               word/byte requests from the CPU, presents address in SETUP,
//               issues one rd/wr strobe, and acknowledges. Accesses that no
//               device decodes within TIMEOUT SETUP cycles complete as NXM.
// Ports       : clk, reset                  - clock, sync active-high reset
//               cpu_req/we/byte/addr/wdata  - CPU request (req sampled in IDLE)
//               cpu_busy/ack/nxm/rdata      - CPU status and read data
//               iopage_addr/rd/wr/byte_op   - device address and strobes
//               data_out                    - write data to devices
//               dev_data_in/decode/stall    - wired-OR device responses
// Revision    : 1.0 - initial release
// ============================================================================
module iopage_master
  import iopage_master_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic                 cpu_byte,
  input  logic [IOPAGE_AW-1:0] cpu_addr,
  input  logic [IOPAGE_DW-1:0] cpu_wdata,
  output logic                 cpu_busy,
  output logic                 cpu_ack,
  output logic                 cpu_nxm,
  output logic [IOPAGE_DW-1:0] cpu_rdata,
  output logic [IOPAGE_AW-1:0] iopage_addr,
  output logic                 iopage_rd,
  output logic                 iopage_wr,
  output logic                 iopage_byte_op,
  output logic [IOPAGE_DW-1:0] data_out,
  input  logic [IOPAGE_DW-1:0] dev_data_in,
  input  logic                 dev_decode,
  input  logic                 dev_stall
);

  localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]           r_state;
  logic [7:0]           r_cnt;
  logic [IOPAGE_AW-1:0] r_addr;
  logic                 r_we;
  logic                 r_byte;
  logic                 r_nxm;
  logic [IOPAGE_DW-1:0] r_wdata;
  logic [IOPAGE_DW-1:0] r_rdata;

  logic [IOPAGE_DW-1:0] w_wr_data;
  logic [IOPAGE_DW-1:0] w_rd_data;
  logic                 w_active;

  iopage_lane_steer u_steer (
    .byte_op   (r_byte),
    .addr_lsb  (r_addr[0]),
    .wdata     (r_wdata),
    .dev_rdata (dev_data_in),
    .wr_data   (w_wr_data),
    .rd_data   (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_byte  <= 1'b0;
      r_nxm   <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= 8'd0;
          if (cpu_req) begin
            r_addr  <= cpu_addr;
            r_we    <= cpu_we;
            r_byte  <= cpu_byte;
            r_wdata <= cpu_wdata;
            r_nxm   <= 1'b0;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (dev_decode && !dev_stall) begin
            r_state <= ST_STROBE;
          end else if (r_cnt == C_CNT_LAST) begin
            // Nobody answered: finish without a strobe and return zero data.
            r_nxm   <= 1'b1;
            r_rdata <= '0;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_STROBE: begin
          if (!r_we) r_rdata <= w_rd_data;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Address, qualifier and write data are only driven while an access owns
  // the bus so the wired-OR device side sees zeros otherwise.
  assign w_active       = (r_state == ST_SETUP) || (r_state == ST_STROBE);
  assign iopage_addr    = w_active ? dev_addr(r_addr, r_we, r_byte) : '0;
  assign iopage_byte_op = w_active & r_byte;
  assign data_out       = (w_active && r_we) ? w_wr_data : '0;
  assign iopage_rd      = (r_state == ST_STROBE) && !r_we;
  assign iopage_wr      = (r_state == ST_STROBE) && r_we;

  assign cpu_busy  = (r_state != ST_IDLE);
  assign cpu_ack   = (r_state == ST_DONE);
  assign cpu_nxm   = cpu_ack & r_nxm;
  assign cpu_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_iopage_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_iopage_master
// Description : Directed self-checking bench for iopage_master. Cycle 0 is
//               the cycle in which cpu_req is high; outputs are sampled 1ns
//               after each rising edge.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iopage_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_byte;
  logic [12:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_busy, cpu_ack, cpu_nxm;
  logic [15:0] cpu_rdata;
  logic [12:0] iopage_addr;
  logic        iopage_rd, iopage_wr, iopage_byte_op;
  logic [15:0] data_out;
  logic [15:0] dev_data_in;
  logic        dev_decode, dev_stall;

  int checks = 0;
  int errors = 0;

  // Observations gathered by run_access
  int          rd_first, wr_first, ack_first, rd_cnt, wr_cnt, ack_cnt;
  logic [12:0] setup_addr, strobe_addr;
  logic        strobe_byte, ack_nxm;
  logic [15:0] strobe_data, ack_rdata;

  logic [50:0] all_out;
  assign all_out = {cpu_busy, cpu_ack, cpu_nxm, cpu_rdata, iopage_addr,
                    iopage_rd, iopage_wr, iopage_byte_op, data_out};

  always #5 clk = ~clk;

  iopage_master #(.TIMEOUT(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_byte       (cpu_byte),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_busy       (cpu_busy),
    .cpu_ack        (cpu_ack),
    .cpu_nxm        (cpu_nxm),
    .cpu_rdata      (cpu_rdata),
    .iopage_addr    (iopage_addr),
    .iopage_rd      (iopage_rd),
    .iopage_wr      (iopage_wr),
    .iopage_byte_op (iopage_byte_op),
    .data_out       (data_out),
    .dev_data_in    (dev_data_in),
    .dev_decode     (dev_decode),
    .dev_stall      (dev_stall)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issues a request in the current cycle (cycle 0) and watches ncycles more.
  // dev_stall is high in cycles 1..stall_cycles; a second req pulse is
  // issued in cycle req2 (0 = none).
  task automatic run_access(input logic we, input logic bop, input logic [12:0] a,
                            input logic [15:0] wd, input int stall_cycles,
                            input int req2, input int ncycles);
    rd_first = -1; wr_first = -1; ack_first = -1;
    rd_cnt = 0; wr_cnt = 0; ack_cnt = 0;
    setup_addr = '0; strobe_addr = '0; strobe_byte = 1'b0; strobe_data = '0;
    ack_nxm = 1'b0; ack_rdata = 16'hdead;
    cpu_we = we; cpu_byte = bop; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
    dev_stall = 1'b0;
    for (int c = 1; c <= ncycles; c++) begin
      next_cycle();
      cpu_req   = (c == req2);
      if (c == req2) cpu_addr = 13'o00002;
      dev_stall = (c <= stall_cycles);
      if (c == 1) setup_addr = iopage_addr;
      if (iopage_rd) begin
        rd_cnt++;
        if (rd_first < 0) rd_first = c;
        strobe_addr = iopage_addr; strobe_byte = iopage_byte_op;
      end
      if (iopage_wr) begin
        wr_cnt++;
        if (wr_first < 0) wr_first = c;
        strobe_addr = iopage_addr; strobe_byte = iopage_byte_op; strobe_data = data_out;
      end
      if (cpu_ack) begin
        ack_cnt++;
        if (ack_first < 0) ack_first = c;
        ack_nxm = cpu_nxm; ack_rdata = cpu_rdata;
      end
    end
    cpu_req = 1'b0; dev_stall = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; dev_data_in = '0; dev_decode = 1'b0; dev_stall = 1'b0;
    next_cycle();
    next_cycle();
    checks++;
    if (all_out !== 51'd0) begin
      errors++; $display("FAIL reset_outputs got %0h exp 0", all_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_word_read();
    dev_decode = 1'b1; dev_data_in = 16'o000340;
    run_access(1'b0, 1'b0, 13'o17776, 16'd0, 0, 0, 6);
    checks++; if (setup_addr !== 13'o17776) begin errors++; $display("FAIL wr_rd setup_addr got %0o exp 17776", setup_addr); end
    checks++; if (rd_first !== 2 || rd_cnt !== 1) begin errors++; $display("FAIL wr_rd rd_strobe got cyc %0d cnt %0d exp cyc 2 cnt 1", rd_first, rd_cnt); end
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL wr_rd wr_cnt got %0d exp 0", wr_cnt); end
    checks++; if (strobe_addr !== 13'o17776) begin errors++; $display("FAIL wr_rd strobe_addr got %0o exp 17776", strobe_addr); end
    checks++; if (ack_first !== 3 || ack_cnt !== 1) begin errors++; $display("FAIL wr_rd ack got cyc %0d cnt %0d exp cyc 3 cnt 1", ack_first, ack_cnt); end
    checks++; if (ack_nxm !== 1'b0 || ack_rdata !== 16'o000340) begin errors++; $display("FAIL wr_rd ack_data got nxm %0b data %0o exp nxm 0 data 340", ack_nxm, ack_rdata); end
    checks++; if (cpu_rdata !== 16'o000340) begin errors++; $display("FAIL wr_rd rdata_hold got %0o exp 340", cpu_rdata); end
  endtask

  task automatic test_byte_read();
    dev_decode = 1'b1; dev_data_in = 16'o170340;
    run_access(1'b0, 1'b1, 13'o17777, 16'd0, 0, 0, 5);
    checks++; if (strobe_addr !== 13'o17776 || strobe_byte !== 1'b1) begin errors++; $display("FAIL br_odd strobe got addr %0o byte %0b exp 17776 1", strobe_addr, strobe_byte); end
    checks++; if (ack_first !== 3 || ack_rdata !== 16'o000360) begin errors++; $display("FAIL br_odd ack got cyc %0d data %0o exp 3 360", ack_first, ack_rdata); end
    run_access(1'b0, 1'b1, 13'o17776, 16'd0, 0, 0, 5);
    checks++; if (ack_first !== 3 || ack_rdata !== 16'o000340) begin errors++; $display("FAIL br_even ack got cyc %0d data %0o exp 3 340", ack_first, ack_rdata); end
  endtask

  task automatic test_byte_write();
    dev_decode = 1'b1; dev_data_in = 16'd0;
    run_access(1'b1, 1'b1, 13'o17777, 16'o000025, 0, 0, 5);
    checks++; if (wr_first !== 2 || wr_cnt !== 1 || rd_cnt !== 0) begin errors++; $display("FAIL bw strobes got wr cyc %0d wr %0d rd %0d exp 2 1 0", wr_first, wr_cnt, rd_cnt); end
    checks++; if (strobe_addr !== 13'o17777 || strobe_byte !== 1'b1) begin errors++; $display("FAIL bw addr got %0o byte %0b exp 17777 1", strobe_addr, strobe_byte); end
    checks++; if (strobe_data !== 16'o012425) begin errors++; $display("FAIL bw data_out got %0o exp 12425", strobe_data); end
    checks++; if (ack_first !== 3 || ack_nxm !== 1'b0) begin errors++; $display("FAIL bw ack got cyc %0d nxm %0b exp 3 0", ack_first, ack_nxm); end
  endtask

  task automatic test_word_write_odd();
    dev_decode = 1'b1;
    run_access(1'b1, 1'b0, 13'o17777, 16'o123456, 0, 0, 5);
    checks++; if (strobe_addr !== 13'o17776 || strobe_byte !== 1'b0) begin errors++; $display("FAIL ww_odd addr got %0o byte %0b exp 17776 0", strobe_addr, strobe_byte); end
    checks++; if (strobe_data !== 16'o123456 || wr_cnt !== 1) begin errors++; $display("FAIL ww_odd data got %0o cnt %0d exp 123456 1", strobe_data, wr_cnt); end
  endtask

  task automatic test_nxm();
    dev_decode = 1'b0; dev_data_in = 16'o177777;
    run_access(1'b0, 1'b0, 13'o10000, 16'd0, 0, 0, 22);
    checks++; if (rd_cnt !== 0 || wr_cnt !== 0) begin errors++; $display("FAIL nxm strobes got rd %0d wr %0d exp 0 0", rd_cnt, wr_cnt); end
    checks++; if (ack_first !== 17 || ack_cnt !== 1) begin errors++; $display("FAIL nxm ack got cyc %0d cnt %0d exp 17 1", ack_first, ack_cnt); end
    checks++; if (ack_nxm !== 1'b1 || ack_rdata !== 16'd0) begin errors++; $display("FAIL nxm flag got nxm %0b data %0o exp 1 0", ack_nxm, ack_rdata); end
  endtask

  task automatic test_stall_ignore();
    dev_decode = 1'b1; dev_data_in = 16'o000123;
    run_access(1'b0, 1'b0, 13'o17546, 16'd0, 3, 2, 10);
    checks++; if (rd_first !== 5 || rd_cnt !== 1) begin errors++; $display("FAIL stall rd got cyc %0d cnt %0d exp 5 1", rd_first, rd_cnt); end
    checks++; if (ack_first !== 6 || ack_cnt !== 1) begin errors++; $display("FAIL stall ack got cyc %0d cnt %0d exp 6 1", ack_first, ack_cnt); end
    checks++; if (strobe_addr !== 13'o17546 || ack_rdata !== 16'o000123) begin errors++; $display("FAIL stall data got addr %0o data %0o exp 17546 123", strobe_addr, ack_rdata); end
  endtask

  task automatic test_back_to_back();
    dev_decode = 1'b1; dev_data_in = 16'o052525;
    run_access(1'b0, 1'b0, 13'o17570, 16'd0, 0, 0, 4);
    checks++; if (ack_first !== 3 || ack_rdata !== 16'o052525) begin errors++; $display("FAIL b2b first got cyc %0d data %0o exp 3 52525", ack_first, ack_rdata); end
    run_access(1'b1, 1'b0, 13'o17570, 16'o000777, 0, 0, 4);
    checks++; if (wr_first !== 2 || strobe_data !== 16'o000777 || ack_first !== 3) begin errors++; $display("FAIL b2b second got wr %0d data %0o ack %0d exp 2 777 3", wr_first, strobe_data, ack_first); end
  endtask

  task automatic test_reset_mid();
    int acks;
    // Reset while waiting in SETUP
    dev_decode = 1'b1; dev_stall = 1'b1;
    cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 13'o17776; cpu_req = 1'b1;
    next_cycle();
    cpu_req = 1'b0;
    checks++; if (cpu_busy !== 1'b1) begin errors++; $display("FAIL rst_setup busy got %0b exp 1", cpu_busy); end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0; dev_stall = 1'b0;
    checks++; if (all_out !== 51'd0) begin errors++; $display("FAIL rst_setup outputs got %0h exp 0", all_out); end
    acks = 0;
    for (int c = 0; c < 5; c++) begin next_cycle(); if (cpu_ack || iopage_rd) acks++; end
    checks++; if (acks !== 0) begin errors++; $display("FAIL rst_setup late_activity got %0d exp 0", acks); end
    // Reset while the strobe is up
    cpu_req = 1'b1;
    next_cycle();
    cpu_req = 1'b0;
    next_cycle();
    checks++; if (iopage_rd !== 1'b1) begin errors++; $display("FAIL rst_strobe rd got %0b exp 1", iopage_rd); end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    checks++; if (all_out !== 51'd0) begin errors++; $display("FAIL rst_strobe outputs got %0h exp 0", all_out); end
    acks = 0;
    for (int c = 0; c < 5; c++) begin next_cycle(); if (cpu_ack || iopage_rd) acks++; end
    checks++; if (acks !== 0) begin errors++; $display("FAIL rst_strobe late_activity got %0d exp 0", acks); end
    // A fresh request completes normally
    dev_data_in = 16'o000340;
    run_access(1'b0, 1'b0, 13'o17776, 16'd0, 0, 0, 5);
    checks++; if (ack_first !== 3 || ack_cnt !== 1 || ack_rdata !== 16'o000340) begin errors++; $display("FAIL rst_fresh ack got cyc %0d cnt %0d data %0o exp 3 1 340", ack_first, ack_cnt, ack_rdata); end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_read();
    test_byte_write();
    test_word_write_odd();
    test_nxm();
    test_stall_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
`default_nettype wire
